// File: rtl/program_loader.sv
// Framed serial program loader: parses SYNC/LEN/(HI,LO)*/CSUM bytes into text RAM writes
// and holds the core in reset while loading. Optional checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_WIDTH        = 8,
  parameter int          INSTRUCTION_WIDTH = 4,
  parameter int          DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  program_write,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic [ADDR_WIDTH-1:0] program_addr,
  output logic                  core_reset_n,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-9:0]  hi_q;
  logic [7:0]             cnt_q;
  logic                   accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  assign accept = rx_valid & rx_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (accept && rx_data == SYNC_BYTE) state_nxt = S_LEN;
      S_LEN:
        if (accept) begin
          if (rx_data == 8'd0)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_nxt = S_CSUM;
`else
            state_nxt = S_DONE;
`endif
          else
            state_nxt = S_HI;
        end
      S_HI:
        if (accept) state_nxt = S_LO;
      S_LO:
        if (accept) state_nxt = S_WRITE;
      S_WRITE:
        if (cnt_q != 8'd1) state_nxt = S_HI;
        else
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM:
        if (accept) state_nxt = (rx_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      hi_q         <= '0;
      cnt_q        <= '0;
      program_cmd  <= '0;
      program_addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_LEN: if (accept) begin
          cnt_q        <= rx_data;
          program_addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_q       <= '0;
`endif
        end
        S_HI: if (accept) begin
          hi_q <= rx_data[DATA_WIDTH-9:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
`endif
        end
        // Word is assembled on LO acceptance so it is stable for the whole WRITE cycle.
        S_LO: if (accept) begin
          program_cmd <= {hi_q, rx_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ rx_data;
`endif
        end
        S_WRITE: begin
          program_addr <= program_addr + ADDR_WIDTH'(1);
          cnt_q        <= cnt_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready      = (state != S_WRITE);
  assign program_write = (state == S_WRITE);
  assign core_reset_n  = (state == S_IDLE) || (state == S_DONE);
  assign load_done     = (state == S_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign load_error    = (state == S_ERR);
`else
  assign load_error    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader (ADDR_WIDTH=2 to exercise address wrap).
module tb_program_loader;
  localparam int AW = 2;
  localparam int DW = 12;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, program_write, core_reset_n, load_done, load_error;
  logic [DW-1:0] program_cmd;
  logic [AW-1:0] program_addr;

  program_loader #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(4), .DATA_WIDTH(DW), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_write(program_write), .program_cmd(program_cmd), .program_addr(program_addr),
    .core_reset_n(core_reset_n), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] cmd;
    int            cyc;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] fh[$];
  logic [7:0] fl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    wr_t w;
    if (reset && program_write) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        w = exp_q.pop_front();
        chk("write_addr", 32'(program_addr), 32'(w.addr));
        chk("write_cmd", 32'(program_cmd), 32'(w.cmd));
        chk("write_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  // Returns after the accepting edge (+1); waits = cycles spent with rx_ready low.
  task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
    logic acc;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    rx_data  = b;
    rx_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 50) begin
        chk("handshake_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_status(input string name, input bit done, input bit err, input bit crn);
    chk({name, "_done"}, 32'(load_done), 32'(done));
    chk({name, "_error"}, 32'(load_error), 32'(err));
    chk({name, "_core_reset_n"}, 32'(core_reset_n), 32'(crn));
  endtask

  // Sends fh/fl as one frame. abort_hi >= 0 stops right after that word's HI byte.
  task automatic send_frame(input bit bad, input bit cont, input int abort_hi);
    int g, w, len;
    logic [7:0] csum;
    wr_t e;
    len  = fh.size();
    csum = 8'h00;
    g = cont ? 0 : $urandom_range(0, 2);
    send_byte(SYNC, g, w);
    chk("sync_ready", 32'(w), 32'd0);
    chk("core_held_after_sync", 32'(core_reset_n), 32'd0);
    send_byte(8'(len), cont ? 0 : $urandom_range(0, 2), w);
    for (int i = 0; i < len; i++) begin
      g = cont ? 0 : $urandom_range(0, 2);
      send_byte(fh[i], g, w);
      chk("hi_backpressure", 32'(w), (i > 0 && g == 0) ? 32'd1 : 32'd0);
      if (i == abort_hi) return;
      send_byte(fl[i], cont ? 0 : $urandom_range(0, 2), w);
      chk("lo_ready", 32'(w), 32'd0);
      e.addr = AW'(i % (1 << AW));
      e.cmd  = {fh[i][3:0], fl[i]};
      e.cyc  = cyc;
      exp_q.push_back(e);
      csum = csum ^ fh[i] ^ fl[i];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (bad) csum = csum ^ 8'($urandom_range(1, 255));
    g = cont ? 0 : $urandom_range(0, 2);
    send_byte(csum, g, w);
    chk("csum_backpressure", 32'(w), (len > 0 && g == 0) ? 32'd1 : 32'd0);
    check_status("after_csum", !bad, bad, !bad);
`else
    if (len > 0) begin
      check_status("during_last_write", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    check_status("after_frame", 1'b1, 1'b0, 1'b1);
`endif
  endtask

  task automatic rand_frame(input int len);
    fh.delete();
    fl.delete();
    for (int i = 0; i < len; i++) begin
      fh.push_back(8'($urandom));
      fl.push_back(8'($urandom));
    end
  endtask

  initial begin
    int w;
    bit bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_write", 32'(program_write), 32'd0);
    chk("rst_cmd", 32'(program_cmd), 32'd0);
    chk("rst_addr", 32'(program_addr), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;

    // Nominal two-word load
    fh = '{8'h0A, 8'h03}; fl = '{8'h12, 8'h45};
    send_frame(1'b0, 1'b0, -1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    fh = '{8'h0B}; fl = '{8'hCD};
    send_frame(1'b1, 1'b0, -1);
    fh.delete(); fl.delete();
    send_frame(1'b0, 1'b0, -1);
`else
    fh = '{8'h01}; fl = '{8'h23};
    send_frame(1'b0, 1'b0, -1);
`endif

    // Noise after DONE is dropped; in-frame sync byte is data
    send_byte(8'h33, 1, w);
    send_byte(8'h77, 0, w);
    chk("noise_ready", 32'(w), 32'd0);
    check_status("after_noise", 1'b1, 1'b0, 1'b1);
    fh = '{8'hFA}; fl = '{8'hA5};
    send_frame(1'b0, 1'b0, -1);

    // Continuous valid with address wrap
    rand_frame(5);
    send_frame(1'b0, 1'b1, -1);

    // Mid-frame reset after HI of word 3
    rand_frame(5);
    send_frame(1'b0, 1'b1, 2);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(rx_ready), 32'd1);
    chk("abort_write", 32'(program_write), 32'd0);
    chk("abort_cmd", 32'(program_cmd), 32'd0);
    chk("abort_addr", 32'(program_addr), 32'd0);
    check_status("abort", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idle_core", 32'(core_reset_n), 32'd1);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      rand_frame($urandom_range(0, 7));
      bad = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 2) == 0);
`endif
      send_frame(bad, 1'($urandom_range(0, 1)), -1);
    end

    fh.delete(); fl.delete();
    send_frame(1'b0, 1'b0, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader upstream of the MC14500B core wrapper. It receives a byte stream over a valid/ready handshake, parses a framed program image, and writes each assembled instruction word into the text RAM through the wrapper's `program_write`/`program_cmd` path. While an image is loading it holds the core in reset, and it releases the core only after a complete frame with a valid checksum.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: text RAM address width.
- `INSTRUCTION_WIDTH`, default 4: opcode field width.
- `DATA_WIDTH`, default `ADDR_WIDTH + INSTRUCTION_WIDTH`: instruction word width. Must satisfy 9 ≤ `DATA_WIDTH` ≤ 16.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `rx_data`, input, 8: incoming byte.
- `rx_valid`, input, 1: `rx_data` is valid.
- `rx_ready`, output, 1: loader accepts a byte this cycle.
- `program_write`, output, 1: one-cycle write strobe to the text RAM.
- `program_cmd`, output, `DATA_WIDTH`: instruction word to write.
- `program_addr`, output, `ADDR_WIDTH`: text RAM write address.
- `core_reset_n`, output, 1: active-low hold for the core, driving the wrapper `reset`.
- `load_done`, output, 1: last frame loaded and verified.
- `load_error`, output, 1: last frame failed its checksum.

## Operation
- A byte is accepted when `rx_valid & rx_ready` are both high. `rx_ready` is 1 in every state except WRITE.
- Frame format: `SYNC_BYTE`, then `LEN` (word count, 0..255), then `LEN` × (HI, LO), then CSUM.
- Word assembly: `program_cmd = {HI[DATA_WIDTH-9:0], LO}`. Unused HI bits are ignored.
- CSUM is the XOR of all HI and LO bytes. `SYNC_BYTE` and `LEN` are excluded.
- States and transitions:
  - IDLE: accepting `SYNC_BYTE` moves to LEN. Any other byte is dropped.
  - LEN: the accepted byte is stored as the word count. `program_addr` clears to 0 and the running checksum clears to 0. Go to CSUM if the count is 0, otherwise go to HI.
  - HI: the accepted byte is latched. Go to LO.
  - LO: go to WRITE.
  - WRITE: `program_write` is 1 for exactly this cycle. `program_addr` increments at the end of the cycle and wraps modulo 2^`ADDR_WIDTH`. Go to HI if words remain, otherwise go to CSUM.
  - CSUM: a matching byte moves to DONE. A mismatch moves to ERR.
  - DONE: `load_done` = 1 and `core_reset_n` = 1.
  - ERR: `load_error` = 1 and `core_reset_n` = 0.
- Leaving DONE or ERR: accepting `SYNC_BYTE` in either state starts a new load, clears both flags, and goes to LEN. Other bytes are dropped.
- `SYNC_BYTE` values inside a frame are treated as data.
- `core_reset_n` is driven low on the cycle after `SYNC_BYTE` is accepted. It stays low through LEN, HI, LO, WRITE, CSUM and ERR.

## Timing
- Reset values, taking effect on the clock edge with `reset` = 0: state IDLE, `rx_ready` = 1, `program_write` = 0, `program_cmd` = 0, `program_addr` = 0, `load_done` = 0, `load_error` = 0.
- `core_reset_n` resets to 1, so the core runs its preloaded image.
- Write latency: a LO byte accepted in cycle t produces `program_write` in cycle t+1. `program_cmd` and `program_addr` are stable during t+1.
- Throughput: the maximum rate is one word per 3 cycles, because `rx_ready` = 0 during WRITE.
- Release latency: CSUM accepted in cycle t gives `core_reset_n` = 1 and `load_done` = 1 in cycle t+1. The final write always precedes the release.
- `reset` asserted mid-frame aborts the load on that edge: all outputs return to their reset values, and no partial `program_write` is issued.
- `rx_valid` may drop at any time. The FSM holds its state, with no timeout.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: the CSUM byte is expected and checked as described above.
- `PROGRAM_LOADER_CHECKSUM_EN` undefined: there is no CSUM byte and no checksum logic. After the final WRITE, or after LEN = 0, the FSM goes directly to DONE. `load_error` is tied to 0 and ERR is unreachable.

## Test plan
- Nominal load. Send A5 02 0A 12 03 45 5E. Required: writes {addr 0, cmd 12'hA12} then {addr 1, cmd 12'h345}. `core_reset_n` goes 0 after A5 and returns to 1, with `load_done` = 1, one cycle after 5E.
- Bad checksum. Send A5 01 0B CD 00. Required: write {0, 12'hBCD}, `load_error` = 1, `core_reset_n` stays 0. Then send A5 00 00. Required: `load_error` clears, `load_done` = 1, `core_reset_n` = 1.
- Noise and in-frame sync bytes:
  - Send 33 77 before A5 01 FA A5 5F. Required: the leading bytes are ignored and the frame writes {0, 12'hAA5}. HI upper nibble F is discarded.
  - The checksum FA^A5 = 5F is accepted, giving `load_done` = 1.
- Mid-frame reset and backpressure:
  - Hold `rx_valid` high continuously. Required: `rx_ready` = 0 only during WRITE cycles, and no byte is lost.
  - Pull `reset` low after HI of word 3. Required: no further `program_write`, `core_reset_n` = 1, state IDLE.
- Address wrap. With `ADDR_WIDTH` = 2, load 5 words. Required: addresses 0, 1, 2, 3, 0 in order.
- Macro off. With `PROGRAM_LOADER_CHECKSUM_EN` undefined, send A5 01 01 23. Required: write {0, 12'h123}, then `load_done` = 1 two cycles after byte 23 is accepted.
